// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the round-robin 4-way channel arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ          = 4;
  localparam int unsigned IDX_W            = 2;
  localparam int unsigned DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first requester after 'last', wrapping, with 'last' itself
// considered only after all the others.
module rr_pick4 import mux_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = last;
    // Offset NUM_REQ wraps back to 'last', giving it the lowest priority.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = last + IDX_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing a 1-bit data channel among four requesters, with every
// tenure bounded to MAX_HOLD cycles.
module rr_mux4_arbiter import mux_arb_pkg::*; #(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [NUM_REQ-1:0] i_Data,
  output logic [NUM_REQ-1:0] o_Grant,
  output logic               o_Sel1,
  output logic               o_Sel0,
  output logic               o_Valid,
  output logic               o_Data
);

  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               tenure_end;

  rr_pick4 u_pick (
    .req   (i_Req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // In BUSY the owner is always last_q.
  assign tenure_end = !i_Req[last_q] || (cnt_q == HoldLast);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          last_d  = pick_idx;
          cnt_d   = '0;
          grant_d = NUM_REQ'(1) << pick_idx;
          sel_d   = pick_idx;
          valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (!tenure_end) begin
          cnt_d = cnt_q + HOLD_W'(1);
        end else if (pick_found) begin
          // A lone expiring owner is found last by the pick and re-granted here.
          last_d  = pick_idx;
          cnt_d   = '0;
          grant_d = NUM_REQ'(1) << pick_idx;
          sel_d   = pick_idx;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          grant_d = '0;
          sel_d   = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign o_Grant = grant_q;
  assign o_Sel1  = sel_q[1];
  assign o_Sel0  = sel_q[0];
  assign o_Valid = valid_q;
  assign o_Data  = valid_q & i_Data[sel_q];

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD=8 and MAX_HOLD=2) share stimulus and are
// compared against a tenure-level reference model.
module tb_rr_mux4_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;

  logic [3:0] g8, g2;
  logic       s81, s80, v8, d8;
  logic       s21, s20, v2, d2;

  int checks = 0;
  int errors = 0;

  rr_mux4_arbiter #(.MAX_HOLD(8), .HOLD_W(8)) dut8 (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .i_Req   (req),
    .i_Data  (din),
    .o_Grant (g8),
    .o_Sel1  (s81),
    .o_Sel0  (s80),
    .o_Valid (v8),
    .o_Data  (d8)
  );

  rr_mux4_arbiter #(.MAX_HOLD(2), .HOLD_W(8)) dut2 (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .i_Req   (req),
    .i_Data  (din),
    .o_Grant (g2),
    .o_Sel1  (s21),
    .o_Sel0  (s20),
    .o_Valid (v2),
    .o_Data  (d2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: owner (-1 = idle), pointer, and length of the current tenure in cycles.
  int own[2];
  int lst[2];
  int ten[2];
  int hold[2] = '{8, 2};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      own[i] = -1;
      lst[i] = 3;
      ten[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int p;
    if (own[i] >= 0 && req[own[i]] && ten[i] < hold[i]) begin
      ten[i] = ten[i] + 1;
    end else begin
      own[i] = -1;
      for (int k = 1; k <= 4; k++) begin
        p = (lst[i] + k) % 4;
        if (own[i] < 0 && req[p]) begin
          own[i] = p;
          lst[i] = p;
          ten[i] = 1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  function automatic logic [7:0] exp_of(input int i);
    logic [3:0] g;
    logic [1:0] s;
    if (own[i] < 0) return 8'h00;
    g = 4'b0001 << own[i];
    s = 2'(own[i]);
    return {g, s, 1'b1, din[own[i]]};
  endfunction

  function automatic logic [15:0] got_all();
    return {g8, s81, s80, v8, d8, g2, s21, s20, v2, d2};
  endfunction

  function automatic logic [15:0] exp_all();
    return {exp_of(0), exp_of(1)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    din   = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (got_all() !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold c%0d: got %h want 0000", c, got_all());
      end
    end
    req   = 4'b0000;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (got_all() !== 16'h0000) begin
        errors++;
        $display("FAIL reset_idle c%0d: got %h want 0000", c, got_all());
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    din = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      if (c == 5) req = 4'b0000;
      @(negedge clk);
      checks++;
      if (got_all() !== exp_all()) begin
        errors++;
        $display("FAIL single c%0d: got %h want %h", c, got_all(), exp_all());
      end
      if (c == 1) begin
        checks++;
        if ({g8, s81, s80, v8, d8} !== 8'b0100_10_1_1) begin
          errors++;
          $display("FAIL single_first: got %b want 01001011", {g8, s81, s80, v8, d8});
        end
      end
      if (c == 5) begin
        checks++;
        if (v8 !== 1'b0) begin
          errors++;
          $display("FAIL single_drop: valid got %b want 0", v8);
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] want;
    do_reset();
    req = 4'b1111;
    din = 4'b1010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      want = 4'b0001 << (((c - 1) / 2) % 4);
      checks++;
      if (g2 !== want || v2 !== 1'b1) begin
        errors++;
        $display("FAIL fairness c%0d: grant %b valid %b want %b 1", c, g2, v2, want);
      end
      checks++;
      if (got_all() !== exp_all()) begin
        errors++;
        $display("FAIL fairness_model c%0d: got %h want %h", c, got_all(), exp_all());
      end
    end
  endtask

  task automatic test_expiry();
    do_reset();
    req = 4'b0010;
    din = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (g8 !== 4'b0010 || v8 !== 1'b1 || d8 !== 1'b1) begin
        errors++;
        $display("FAIL expiry c%0d: grant %b valid %b data %b want 0010 1 1", c, g8, v8, d8);
      end
      checks++;
      if (got_all() !== exp_all()) begin
        errors++;
        $display("FAIL expiry_model c%0d: got %h want %h", c, got_all(), exp_all());
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b1001;
    din = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) req = 4'b1000;
      @(negedge clk);
      checks++;
      if (got_all() !== exp_all()) begin
        errors++;
        $display("FAIL early_model c%0d: got %h want %h", c, got_all(), exp_all());
      end
      if (c == 3) begin
        checks++;
        if ({g8, s81, s80, v8} !== 7'b1000_11_1) begin
          errors++;
          $display("FAIL early_switch: got %b want 1000111", {g8, s81, s80, v8});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010;
    din = 4'b1111;
    repeat (3) @(negedge clk);
    checks++;
    if (g8 !== 4'b0010) begin
      errors++;
      $display("FAIL mid_pre: grant got %b want 0010", g8);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (got_all() !== 16'h0000) begin
      errors++;
      $display("FAIL mid_async: got %h want 0000", got_all());
    end
    @(negedge clk);
    req   = 4'b1010;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({g8, s81, s80, v8} !== 7'b0010_01_1 || g2 !== 4'b0010) begin
      errors++;
      $display("FAIL mid_first: got %b/%b want 0010011/0010", {g8, s81, s80, v8}, g2);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      din = 4'($urandom);
      @(negedge clk);
      checks++;
      if (got_all() !== exp_all()) begin
        errors++;
        $display("FAIL random c%0d: req %b got %h want %h", c, req, got_all(), exp_all());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = 4'b0000;
    test_reset();
    test_single();
    test_fairness();
    test_expiry();
    test_early_release();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
